// File: rtl/alert_controller.sv
// Buzzer owner for the clock: arbitrates alarm, timer and hourly chime alerts,
// shapes each into its buzzer pattern, auto-silences and handles alarm snooze.
module alert_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CHIME_SECS  = 2,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_hit,
    input  logic       timer_done,
    input  logic       hour_tick,
    input  logic       chime_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic [1:0] alert_src,
    output logic       alert_active,
    output logic       snooze_pending,
    output logic [8:0] snooze_left
);

    // state        | meaning
    // S_IDLE       | quiet, waiting for a request
    // S_RING_ALARM | alarm ringing, buzzer toggles every second
    // S_RING_TIMER | timer ringing, buzzer steady on
    // S_CHIME      | hourly chime, buzzer on for CHIME_SECS
    // S_SNOOZE     | alarm snoozed, counting snooze_left down to re-ring
    typedef enum logic [2:0] {
        S_IDLE,
        S_RING_ALARM,
        S_RING_TIMER,
        S_CHIME,
        S_SNOOZE
    } state_t;

    localparam logic [7:0] RING_LAST   = 8'(RING_SECS - 1);
    localparam logic [7:0] CHIME_LAST  = 8'(CHIME_SECS - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [8:0] snooze_left_q, snooze_left_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       timer_pend_q, timer_pend_d;

    logic       buzzer_q, buzzer_d;
    logic [1:0] alert_src_q, alert_src_d;
    logic       alert_active_q, alert_active_d;
    logic       snooze_pending_q, snooze_pending_d;

    logic       snooze_as_stop;
    logic       eval_idle;

    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snooze_left_d = snooze_left_q;
        snooze_cnt_d  = snooze_cnt_q;
        timer_pend_d  = timer_pend_q;
        eval_idle     = 1'b0;

        snooze_as_stop = snooze_btn &&
                         (((state_q == S_RING_ALARM) && (snooze_cnt_q == SNOOZE_MAX)) ||
                          (state_q == S_RING_TIMER));

        // Stop is applied first; any request in the same cycle is then judged as from IDLE.
        if (stop_btn || snooze_as_stop) begin
            state_d       = S_IDLE;
            ring_cnt_d    = 8'd0;
            snooze_left_d = 9'd0;
            snooze_cnt_d  = 2'd0;
            timer_pend_d  = 1'b0;
            eval_idle     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: eval_idle = 1'b1;
                S_RING_ALARM: begin
                    if (timer_done) timer_pend_d = 1'b1;
                    if (snooze_btn) begin
                        state_d       = S_SNOOZE;
                        ring_cnt_d    = 8'd0;
                        snooze_left_d = SNOOZE_LOAD;
                        snooze_cnt_d  = snooze_cnt_q + 2'd1;
                    end else if (ring_cnt_q == RING_LAST) begin
                        state_d      = S_IDLE;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 2'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                S_RING_TIMER: begin
                    if (alarm_hit) begin
                        state_d      = S_RING_ALARM;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 2'd0;
                        timer_pend_d = 1'b1;
                    end else if (ring_cnt_q == RING_LAST) begin
                        state_d      = S_IDLE;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 2'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                S_CHIME: begin
                    if (alarm_hit) begin
                        state_d      = S_RING_ALARM;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 2'd0;
                        if (timer_done) timer_pend_d = 1'b1;
                    end else if (timer_done) begin
                        state_d      = S_RING_TIMER;
                        ring_cnt_d   = 8'd0;
                        timer_pend_d = 1'b0;
                    end else if (ring_cnt_q == CHIME_LAST) begin
                        state_d    = S_IDLE;
                        ring_cnt_d = 8'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                S_SNOOZE: begin
                    if (timer_done) timer_pend_d = 1'b1;
                    if (alarm_hit) begin
                        state_d       = S_RING_ALARM;
                        ring_cnt_d    = 8'd0;
                        snooze_cnt_d  = 2'd0;
                        snooze_left_d = 9'd0;
                    end else if (snooze_left_q == 9'd1) begin
                        state_d       = S_RING_ALARM;
                        ring_cnt_d    = 8'd0;
                        snooze_left_d = 9'd0;
                    end else begin
                        snooze_left_d = snooze_left_q - 9'd1;
                    end
                end
                default: begin
                    state_d       = S_IDLE;
                    ring_cnt_d    = 8'd0;
                    snooze_left_d = 9'd0;
                    snooze_cnt_d  = 2'd0;
                    timer_pend_d  = 1'b0;
                end
            endcase
        end

        if (eval_idle) begin
            if (alarm_hit) begin
                state_d      = S_RING_ALARM;
                ring_cnt_d   = 8'd0;
                snooze_cnt_d = 2'd0;
                if (timer_done) timer_pend_d = 1'b1;
            end else if (timer_done || timer_pend_d) begin
                state_d      = S_RING_TIMER;
                ring_cnt_d   = 8'd0;
                timer_pend_d = 1'b0;
            end else if (hour_tick && chime_en) begin
                state_d    = S_CHIME;
                ring_cnt_d = 8'd0;
            end
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        buzzer_d         = 1'b0;
        alert_src_d      = 2'b00;
        alert_active_d   = 1'b0;
        snooze_pending_d = 1'b0;
        case (state_d)
            S_RING_ALARM: begin
                buzzer_d       = ~ring_cnt_d[0];
                alert_src_d    = 2'b01;
                alert_active_d = 1'b1;
            end
            S_RING_TIMER: begin
                buzzer_d       = 1'b1;
                alert_src_d    = 2'b10;
                alert_active_d = 1'b1;
            end
            S_CHIME: begin
                buzzer_d       = 1'b1;
                alert_src_d    = 2'b11;
                alert_active_d = 1'b1;
            end
            S_SNOOZE: begin
                alert_src_d      = 2'b01;
                snooze_pending_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            ring_cnt_q       <= 8'd0;
            snooze_left_q    <= 9'd0;
            snooze_cnt_q     <= 2'd0;
            timer_pend_q     <= 1'b0;
            buzzer_q         <= 1'b0;
            alert_src_q      <= 2'b00;
            alert_active_q   <= 1'b0;
            snooze_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            ring_cnt_q       <= ring_cnt_d;
            snooze_left_q    <= snooze_left_d;
            snooze_cnt_q     <= snooze_cnt_d;
            timer_pend_q     <= timer_pend_d;
            buzzer_q         <= buzzer_d;
            alert_src_q      <= alert_src_d;
            alert_active_q   <= alert_active_d;
            snooze_pending_q <= snooze_pending_d;
        end
    end

    assign buzzer         = buzzer_q;
    assign alert_src      = alert_src_q;
    assign alert_active   = alert_active_q;
    assign snooze_pending = snooze_pending_q;
    assign snooze_left    = snooze_left_q;

endmodule

// File: tb/tb_alert_controller.sv
// Self-checking bench for alert_controller: directed scenarios plus random
// pulses, every cycle compared against a seconds-remaining reference model.
module tb_alert_controller;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int CHIME_SECS  = 2;
    localparam int MAX_SNOOZE  = 3;

    localparam int M_IDLE = 0, M_ALARM = 1, M_TIMER = 2, M_CHIME = 3, M_SNOOZE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alarm_hit = 1'b0, timer_done = 1'b0, hour_tick = 1'b0, chime_en = 1'b0;
    logic       snooze_btn = 1'b0, stop_btn = 1'b0;
    logic       buzzer;
    logic [1:0] alert_src;
    logic       alert_active, snooze_pending;
    logic [8:0] snooze_left;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current alert kind, seconds left in it, seconds elapsed.
    int m_mode, m_left, m_elapsed, m_snz_left, m_snoozes;
    bit m_pend;

    always #5 clk = ~clk;

    alert_controller #(
        .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS),
        .CHIME_SECS(CHIME_SECS), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .alarm_hit(alarm_hit), .timer_done(timer_done),
        .hour_tick(hour_tick), .chime_en(chime_en), .snooze_btn(snooze_btn),
        .stop_btn(stop_btn), .buzzer(buzzer), .alert_src(alert_src),
        .alert_active(alert_active), .snooze_pending(snooze_pending),
        .snooze_left(snooze_left)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_left = 0; m_elapsed = 0; m_snz_left = 0; m_snoozes = 0; m_pend = 1'b0;
    endfunction

    function automatic void model_start(int mode);
        m_mode    = mode;
        m_elapsed = 0;
        m_left    = (mode == M_CHIME) ? CHIME_SECS : RING_SECS;
    endfunction

    function automatic void model_step(bit a, bit t, bit h, bit ce, bit sn, bit sp);
        bit from_idle = 1'b0;
        bit stop = sp || (sn && ((m_mode == M_ALARM && m_snoozes >= MAX_SNOOZE) || m_mode == M_TIMER));
        if (stop) begin
            m_mode = M_IDLE; m_pend = 1'b0; m_snoozes = 0; m_snz_left = 0;
            from_idle = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: from_idle = 1'b1;
                M_ALARM: begin
                    if (t) m_pend = 1'b1;
                    if (sn) begin
                        m_snoozes++; m_snz_left = SNOOZE_SECS; m_mode = M_SNOOZE;
                    end else if (m_left == 1) begin
                        m_mode = M_IDLE; m_snoozes = 0;
                    end else begin
                        m_left--; m_elapsed++;
                    end
                end
                M_TIMER: begin
                    if (a) begin
                        model_start(M_ALARM); m_pend = 1'b1; m_snoozes = 0;
                    end else if (m_left == 1) begin
                        m_mode = M_IDLE; m_snoozes = 0;
                    end else begin
                        m_left--; m_elapsed++;
                    end
                end
                M_CHIME: begin
                    if (a) begin
                        model_start(M_ALARM); m_snoozes = 0;
                        if (t) m_pend = 1'b1;
                    end else if (t) begin
                        model_start(M_TIMER); m_pend = 1'b0;
                    end else if (m_left == 1) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_left--; m_elapsed++;
                    end
                end
                default: begin
                    if (t) m_pend = 1'b1;
                    if (a) begin
                        model_start(M_ALARM); m_snoozes = 0; m_snz_left = 0;
                    end else if (m_snz_left == 1) begin
                        model_start(M_ALARM); m_snz_left = 0;
                    end else begin
                        m_snz_left--;
                    end
                end
            endcase
        end
        if (from_idle) begin
            if (a) begin
                model_start(M_ALARM); m_snoozes = 0;
                if (t) m_pend = 1'b1;
            end else if (t || m_pend) begin
                model_start(M_TIMER); m_pend = 1'b0;
            end else if (h && ce) begin
                model_start(M_CHIME);
            end
        end
    endfunction

    function automatic logic [31:0] model_out();
        bit       eb = 1'b0, ea = 1'b0, ep = 1'b0;
        int       es = 0, el = 0;
        case (m_mode)
            M_ALARM:  begin eb = (m_elapsed % 2 == 0); es = 1; ea = 1'b1; end
            M_TIMER:  begin eb = 1'b1; es = 2; ea = 1'b1; end
            M_CHIME:  begin eb = 1'b1; es = 3; ea = 1'b1; end
            M_SNOOZE: begin es = 1; ep = 1'b1; el = m_snz_left; end
            default: ;
        endcase
        return 32'({eb, 2'(es), ea, ep, 9'(el)});
    endfunction

    function automatic logic [31:0] dut_out();
        return 32'({buzzer, alert_src, alert_active, snooze_pending, snooze_left});
    endfunction

    task automatic step(input string tag, input bit a, input bit t, input bit h,
                        input bit ce, input bit sn, input bit sp);
        alarm_hit = a; timer_done = t; hour_tick = h; chime_en = ce;
        snooze_btn = sn; stop_btn = sp;
        @(posedge clk);
        model_step(a, t, h, ce, sn, sp);
        #1;
        check_eq(tag, dut_out(), model_out());
        alarm_hit = 1'b0; timer_done = 1'b0; hour_tick = 1'b0;
        snooze_btn = 1'b0; stop_btn = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, chime_en, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        bit seen;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", dut_out(), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Alarm at cycle 10: 60 cycles of 1,0,1,0 then silence.
        quiet("pre_alarm", 9);
        step("alarm_start", 1, 0, 0, 0, 0, 0);
        check_eq("alarm_src_first", 32'(alert_src), 32'd1);
        cnt = 1;
        for (int i = 1; i < RING_SECS; i++) begin
            step("alarm_ring", 0, 0, 0, 0, 0, 0);
            if (buzzer) cnt++;
        end
        check_eq("alarm_on_cycles", 32'(cnt), 32'(RING_SECS / 2));
        step("alarm_silence", 0, 0, 0, 0, 0, 0);
        check_eq("alarm_silenced", 32'({buzzer, alert_src}), 32'd0);

        // Snooze three times, fourth snooze acts as stop.
        step("snz_alarm", 1, 0, 0, 0, 0, 0);
        for (int k = 0; k <= MAX_SNOOZE; k++) begin
            quiet("snz_ring", 5);
            step("snz_press", 0, 0, 0, 0, 1, 0);
            if (k < MAX_SNOOZE) begin
                check_eq("snz_loaded", 32'(snooze_left), 32'(SNOOZE_SECS));
                quiet("snz_count", SNOOZE_SECS);
                check_eq("snz_rering", 32'({buzzer, alert_src, snooze_pending}), 32'b1010);
            end
        end
        check_eq("snz_fourth_stop", 32'({alert_src, snooze_pending}), 32'd0);

        // Timer during alarm then stop: timer dropped.
        step("tp_alarm", 1, 0, 0, 0, 0, 0);
        quiet("tp_ring", 3);
        step("tp_timer", 0, 1, 0, 0, 0, 0);
        quiet("tp_ring2", 2);
        step("tp_stop", 0, 0, 0, 0, 0, 1);
        quiet("tp_after_stop", 3);
        check_eq("tp_dropped", 32'(alert_src), 32'd0);

        // Timer during alarm then auto-silence: timer follows.
        step("tp2_alarm", 1, 0, 0, 0, 0, 0);
        step("tp2_timer", 0, 1, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 2 * RING_SECS + 5; i++) begin
            step("tp2_run", 0, 0, 0, 0, 0, 0);
            if (alert_src == 2'b10 && buzzer) cnt++;
        end
        check_eq("tp2_timer_cycles", 32'(cnt), 32'(RING_SECS));

        // Chime, chime dropped while ringing, chime disabled.
        step("chime", 0, 0, 1, 1, 0, 0);
        check_eq("chime_src", 32'({buzzer, alert_src}), 32'b111);
        quiet("chime_run", 3);
        step("ct_timer", 0, 1, 0, 1, 0, 0);
        quiet("ct_ring", 5);
        step("ct_hour", 0, 0, 1, 1, 0, 0);
        check_eq("ct_hour_dropped", 32'(alert_src), 32'd2);
        step("ct_stop", 0, 0, 0, 1, 0, 1);
        quiet("ct_idle", 2);
        step("chime_off", 0, 0, 1, 0, 0, 0);
        check_eq("chime_disabled", 32'(alert_src), 32'd0);

        // All three requests coincide: alarm, then timer, never chime.
        seen = 1'b0;
        step("tri_hit", 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 2 * RING_SECS + 5; i++) begin
            step("tri_run", 0, 0, 0, 1, 0, 0);
            if (alert_src == 2'b11) seen = 1'b1;
        end
        check_eq("tri_no_chime", 32'(seen), 32'd0);

        // Stop plus alarm during timer ring.
        step("sa_timer", 0, 1, 0, 0, 0, 0);
        quiet("sa_ring", 4);
        step("sa_stop_alarm", 1, 0, 0, 0, 0, 1);
        quiet("sa_after", RING_SECS + 3);

        // Asynchronous reset during timer ring and during snooze.
        step("ar_timer", 0, 1, 0, 0, 0, 0);
        quiet("ar_ring", 4);
        #2 reset = 1'b0;
        #1 check_eq("ar_buzzer_async", 32'({buzzer, alert_src, alert_active}), 32'd0);
        do_reset();
        quiet("ar_after", 3);
        step("ar_alarm", 1, 0, 0, 0, 0, 0);
        step("ar_snooze", 0, 0, 0, 0, 1, 0);
        quiet("ar_snz", 10);
        #2 reset = 1'b0;
        #1 check_eq("ar_snooze_async", 32'({snooze_pending, snooze_left}), 32'd0);
        do_reset();
        quiet("ar_after2", 3);

        // Random pulses.
        for (int i = 0; i < 6000; i++) begin
            bit a, t, h, ce, sn, sp;
            a  = ($urandom_range(0, 59) == 0);
            t  = ($urandom_range(0, 59) == 0);
            h  = ($urandom_range(0, 29) == 0);
            ce = ($urandom_range(0, 3) != 0);
            sn = ($urandom_range(0, 14) == 0);
            sp = ($urandom_range(0, 79) == 0);
            step("random", a, t, h, ce, sn, sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alert_controller.md
Name: alert_controller

Overview:
- Single owner of the one physical buzzer in the clock design.
- Arbitrates three alert sources onto it: alarm-match pulse, timer-expiry pulse and hourly chime. The alarm and timer pulses come from the existing alarm and timer blocks; the chime pulse comes from the timekeeper rollover.
- Shapes each alert into its own buzzer pattern, applies an auto-silence timeout and implements alarm snooze.
- Sits between the digital_clock outputs and the board buzzer pin. clk is the 1 Hz tick, so one cycle is one second.

Parameters:
- RING_SECS, 60: cycles an alarm or timer rings before auto-silence; legal range 2..255.
- SNOOZE_SECS, 300: snooze delay in cycles; legal range 2..511.
- CHIME_SECS, 2: buzzer-on cycles for the hourly chime; legal range 1..RING_SECS.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; the next snooze acts as stop; legal range 1..3.

Ports:
- clk  input  1  1 Hz system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- alarm_hit  input  1  1-cycle pulse; alarm time matched.
- timer_done  input  1  1-cycle pulse; timer expired.
- hour_tick  input  1  1-cycle pulse at hh:00:00.
- chime_en  input  1  level; enables the hourly chime.
- snooze_btn  input  1  1-cycle pulse, pre-debounced.
- stop_btn  input  1  1-cycle pulse, pre-debounced.
- buzzer  output  1  registered buzzer drive.
- alert_src  output  2  00 none, 01 alarm, 10 timer, 11 chime.
- alert_active  output  1  high while the buzzer pattern is running.
- snooze_pending  output  1  high in SNOOZE.
- snooze_left  output  9  remaining snooze cycles; 0 outside SNOOZE.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; timer_pend, ring_cnt and snooze_cnt cleared. Normal operation resumes on the first clk edge after reset goes high.
- All outputs are registered. A request sampled at edge N gives buzzer, alert_src and alert_active updated after edge N, i.e. valid in cycle N+1.
- States: IDLE, RING_ALARM, RING_TIMER, CHIME, SNOOZE.
- Priority when requests coincide: alarm > timer > chime.
- IDLE:
  - alarm_hit -> RING_ALARM.
  - else timer_done or timer_pend -> RING_TIMER.
  - else hour_tick & chime_en -> CHIME.
  - Entering any ring state clears ring_cnt to 0.
- Buzzer patterns, with ring_cnt = cycles already spent in the state:
  - RING_ALARM: buzzer = ~ring_cnt[0], i.e. 1,0,1,0...
  - RING_TIMER: buzzer = 1 continuously.
  - CHIME: buzzer = 1.
- Auto-silence:
  - RING_ALARM or RING_TIMER exits to IDLE after RING_SECS cycles (ring_cnt == RING_SECS-1 at the edge). snooze_cnt clears.
  - CHIME exits to IDLE after CHIME_SECS cycles.
- Preemption rules:
  - alarm_hit during RING_TIMER: -> RING_ALARM, ring_cnt = 0, and timer_pend is set so the timer rings afterwards.
  - alarm_hit during CHIME: -> RING_ALARM.
  - timer_done during RING_ALARM or SNOOZE: sets timer_pend.
  - timer_done during CHIME: -> RING_TIMER.
  - hour_tick while not IDLE: dropped, never queued.
- Leaving RING_ALARM to IDLE with timer_pend = 1: the next cycle goes to RING_TIMER, and timer_pend clears on entry.
- snooze_btn:
  - In RING_ALARM with snooze_cnt < MAX_SNOOZE: -> SNOOZE, snooze_left = SNOOZE_SECS, snooze_cnt + 1.
  - In RING_ALARM with snooze_cnt == MAX_SNOOZE: treated as stop.
  - In RING_TIMER: treated as stop.
  - In IDLE, CHIME or SNOOZE: ignored.
- SNOOZE:
  - buzzer = 0 and alert_src = 01.
  - snooze_left decrements each cycle; at snooze_left == 1 the edge goes to RING_ALARM with ring_cnt = 0.
  - alarm_hit during SNOOZE goes to RING_ALARM immediately and resets snooze_cnt to 0.
  - A pending timer (timer_pend) is served only after the alarm sequence fully ends.
- stop_btn: from any non-IDLE state goes to IDLE and clears timer_pend, snooze_cnt and snooze_left. In IDLE it clears timer_pend only.
- Simultaneous events in one cycle:
  - stop and snooze together: stop wins.
  - stop together with any request: stop is applied first, then the request is evaluated from IDLE in the same cycle. Example: stop + alarm_hit during RING_TIMER -> RING_ALARM, timer_pend = 0.
- Counter widths: ring_cnt 8 bits; snooze_left 9 bits; snooze_cnt 2 bits, saturating. No wrap is possible within the legal parameter ranges.
- Reset asserted mid-ring or mid-snooze: buzzer drops asynchronously. Nothing is remembered across reset.

Test Plan:
- Reset low during RING_TIMER -> buzzer goes 0 immediately without a clk edge. After release, IDLE with all outputs 0.
- alarm_hit at cycle 10 -> alert_src = 01 from cycle 11; buzzer 1,0,1,0... for 60 cycles; IDLE at cycle 71 with buzzer 0.
- alarm_hit, then snooze_btn at ring cycle 5 -> snooze_pending = 1, snooze_left = 300 counting down to 1 -> alarm rings again with ring_cnt 0. The 4th snooze acts as stop and returns to IDLE.
- timer_done during RING_ALARM -> timer_pend held. stop_btn -> IDLE with timer dropped. Repeat with auto-silence instead of stop -> RING_TIMER follows with buzzer continuously 1 for 60 cycles.
- hour_tick with chime_en = 1 in IDLE -> alert_src = 11, buzzer 1 for 2 cycles. hour_tick during RING_TIMER -> dropped. hour_tick with chime_en = 0 -> no response.
- alarm_hit + timer_done + hour_tick in the same cycle -> RING_ALARM with timer_pend = 1, then RING_TIMER after it; chime never rings.
